cosim_result_sink: RTL and testbench

Downstream consumer for combinational cosim spec blocks that emit one wide result vector per test step (e.g. 128-bit packed logical-operator results). Accepts result words over valid/ready, buffers them, folds each into a running MISR signature, and serialises them into 32-bit beats for the simulator log/compare port. An FSM bounds each run to NUM_VEC words and signals completion after the buffer drains.

---
 rtl/cosim_sink_pkg.sv | 16 +
 rtl/cosim_sync_fifo.sv | 57 +++++
 rtl/cosim_result_sink.sv | 152 +++++++++++++++
 tb/tb_cosim_result_sink.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_sink_pkg.sv
// Shared types and constants for the cosim result sink: run-state encoding,
// log beat width and the default MISR feedback polynomial.
package cosim_sink_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int BEAT_W = 32;

    localparam logic [127:0] DEFAULT_POLY = 128'h87;

endpackage

// File: rtl/cosim_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module cosim_sync_fifo
    import cosim_sink_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign count     = wr_ptr_r - rd_ptr_r;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer update; wrap is free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
            end
        end
    end

    // Storage write; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cosim_result_sink.sv
// Collects wide cosim result words, folds them into a MISR signature and
// replays them as 32-bit log beats, bounding each run to NUM_VEC words.
module cosim_result_sink
    import cosim_sink_pkg::*;
#(
    parameter int           WIDTH   = 128,
    parameter int           DEPTH   = 4,
    parameter int           NUM_VEC = 64,
    parameter logic [127:0] POLY    = DEFAULT_POLY
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [BEAT_W-1:0]              out_data,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               signature,
    output logic [$clog2(NUM_VEC+1)-1:0]   word_count,
    output logic                           busy,
    output logic                           done
);

    localparam int NBEAT = WIDTH / BEAT_W;
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int CW    = $clog2(NUM_VEC + 1);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [WIDTH-1:0] POLY_W   = WIDTH'(POLY);
    localparam logic [BW-1:0]    LAST_IDX = BW'(NBEAT - 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(NUM_VEC - 1);

    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                   input logic [WIDTH-1:0] data);
        logic [WIDTH-1:0] fb;
        fb = sig[WIDTH-1] ? POLY_W : {WIDTH{1'b0}};
        return {sig[WIDTH-2:0], 1'b0} ^ fb ^ data;
    endfunction

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] sig_r;
    logic [CW-1:0]    wc_r;
    logic [BW-1:0]    idx_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [WIDTH-1:0] head_s;
    logic [AW:0]      fifo_count_s;

    logic             accept_s;
    logic             beat_fire_s;
    logic             last_beat_s;
    logic             pop_s;
    logic             start_ok_s;

    // in_ready ignores a same-cycle pop: a full FIFO never bypasses.
    assign in_ready    = (state_r == RUN) && !fifo_full_s;
    assign accept_s    = in_valid && in_ready;
    assign out_valid   = !fifo_empty_s;
    assign beat_fire_s = out_valid && out_ready;
    assign last_beat_s = (idx_r == LAST_IDX);
    assign pop_s       = beat_fire_s && last_beat_s;
    assign start_ok_s  = start && ((state_r == IDLE) || (state_r == DONE));

    assign signature  = sig_r;
    assign word_count = wc_r;
    assign busy       = (state_r == RUN) || (state_r == DRAIN);
    assign done       = (state_r == DONE);

    cosim_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_s),
        .push_data (in_data),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (head_s),
        .count     (fifo_count_s)
    );

    // Beat mux; data is zeroed when nothing is queued so the port reads clean.
    always_comb begin
        out_data = {BEAT_W{1'b0}};
        out_last = 1'b0;
        if (out_valid) begin
            out_data = head_s[idx_r*BEAT_W +: BEAT_W];
            out_last = last_beat_s;
        end else begin
            out_data = {BEAT_W{1'b0}};
            out_last = 1'b0;
        end
    end

    // Run-state transitions.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = state_r;
            end
            RUN: begin
                if (accept_s && (wc_r == LAST_CNT)) state_nxt_s = DRAIN;
                else                                state_nxt_s = RUN;
            end
            DRAIN: begin
                // Final beat of the only remaining word leaves the FIFO empty.
                if (pop_s && (fifo_count_s == (AW+1)'(1'b1))) state_nxt_s = DONE;
                else                                          state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Signature and word counter; cleared by an honoured start, held in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_r <= {WIDTH{1'b0}};
            wc_r  <= {CW{1'b0}};
        end else if (start_ok_s) begin
            sig_r <= {WIDTH{1'b0}};
            wc_r  <= {CW{1'b0}};
        end else if (accept_s) begin
            sig_r <= misr_step(sig_r, in_data);
            wc_r  <= wc_r + CW'(1'b1);
        end
    end

    // Beat index within the head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= {BW{1'b0}};
        end else if (beat_fire_s) begin
            idx_r <= last_beat_s ? {BW{1'b0}} : idx_r + BW'(1'b1);
        end
    end

endmodule

// File: tb/tb_cosim_result_sink.sv
// Directed self-checking bench for cosim_result_sink (WIDTH=128, DEPTH=4,
// NUM_VEC=5): beat order, MISR values, stalls, no-bypass, start/reset handling.
module tb_cosim_result_sink;

    localparam int NV = 5;
    localparam int CW = $clog2(NV + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [127:0]     in_data = 128'h0;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_last;
    logic             out_ready;
    logic [127:0]     signature;
    logic [CW-1:0]    word_count;
    logic             busy;
    logic             done;

    logic             orq_man = 1'b1;
    logic             tog_en = 1'b0;
    logic             tog_r = 1'b0;

    int               errors = 0;
    int               checks = 0;
    int               stall_seen = 0;
    logic [32:0]      beats [$];
    logic             prev_stall = 1'b0;
    logic [31:0]      prev_data = 32'h0;
    logic             prev_last = 1'b0;
    logic [127:0]     sig_m;
    logic [127:0]     wa [5];

    cosim_result_sink #(
        .WIDTH   (128),
        .DEPTH   (4),
        .NUM_VEC (NV),
        .POLY    (128'h87)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .signature  (signature),
        .word_count (word_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign out_ready = tog_en ? tog_r : orq_man;

    always @(posedge clk) tog_r <= ~tog_r;

    // Beat collector and stall-hold check, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && tog_en && prev_stall) begin
            checks++;
            stall_seen++;
            assert (out_valid === 1'b1 && out_data === prev_data && out_last === prev_last)
            else begin
                errors++;
                $error("FAIL stall_hold: observed %h/%b expected %h/%b",
                       out_data, out_last, prev_data, prev_last);
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (!rst && out_valid && out_ready) beats.push_back({out_last, out_data});
    end

    function automatic logic [127:0] misr_m(input logic [127:0] s, input logic [127:0] d);
        return (s << 1) ^ (s[127] ? 128'h87 : 128'h0) ^ d;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_word(input logic [127:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk1("push_wait", n < 200, 1'b1);
        tick();
        in_valid = 1'b0;
        in_data  = 128'h0;
    endtask

    task automatic wait_done(input int exp_beats);
        int n;
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        chk1("done_reached", done, 1'b1);
        chk("beats_at_done", 128'(beats.size()), 128'(exp_beats));
    endtask

    task automatic check_beats(input string tag, input logic [127:0] w [5]);
        logic [32:0] e;
        logic [32:0] got;
        for (int i = 0; i < 20; i++) begin
            e[32]   = ((i % 4) == 3);
            e[31:0] = w[i/4][32*(i%4) +: 32];
            got     = (i < beats.size()) ? beats[i] : 33'h0_dead_beef;
            checks++;
            assert (got === e)
            else begin
                errors++;
                $error("FAIL %s_beat%0d: observed %h expected %h", tag, i, got, e);
            end
        end
    endtask

    initial begin
        // Reset state while rst is held
        #2;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", 128'(out_data), 128'h0);
        chk("rst_signature", signature, 128'h0);
        chk("rst_word_count", 128'(word_count), 128'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk1("idle_in_ready", in_ready, 1'b0);

        // Run A: free-flowing sink, signature 1,1 -> 3
        wa = '{128'h1, 128'h1, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98,
               128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
               128'h00000001_00000002_00000003_00000004};
        orq_man = 1'b1;
        pulse_start();
        chk1("A_busy", busy, 1'b1);
        chk1("A_in_ready", in_ready, 1'b1);
        chk("A_wc0", 128'(word_count), 128'd0);
        push_word(wa[0]);
        chk("A_sig1", signature, 128'h1);
        chk("A_wc1", 128'(word_count), 128'd1);
        chk1("A_first_valid", out_valid, 1'b1);
        chk("A_first_data", 128'(out_data), 128'h1);
        chk1("A_first_last", out_last, 1'b0);
        push_word(wa[1]);
        chk("A_sig2", signature, 128'h3);
        chk("A_wc2", 128'(word_count), 128'd2);
        sig_m = 128'h3;
        for (int i = 2; i < 5; i++) begin
            push_word(wa[i]);
            sig_m = misr_m(sig_m, wa[i]);
        end
        chk1("A_drain_busy", busy, 1'b1);
        chk1("A_drain_in_ready", in_ready, 1'b0);
        chk1("A_drain_done", done, 1'b0);
        wait_done(20);
        chk("A_sig_final", signature, sig_m);
        chk("A_wc_final", 128'(word_count), 128'd5);
        chk1("A_done_busy", busy, 1'b0);
        check_beats("A", wa);

        // in_valid while DONE has no effect
        in_valid = 1'b1;
        in_data  = 128'hFFFF;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        chk("done_ign_wc", 128'(word_count), 128'd5);
        chk("done_ign_sig", signature, sig_m);
        chk1("done_ign_in_ready", in_ready, 1'b0);
        chk1("done_ign_out_valid", out_valid, 1'b0);
        chk1("done_ign_done", done, 1'b1);

        // Run B: out_ready toggling, MISR top-bit feedback, start ignored in RUN
        beats.delete();
        wa = '{128'h80000000_00000000_00000000_00000000, 128'h0,
               128'h0F0F0F0F_11112222_33334444_55556666,
               128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C,
               128'h12345678_9ABCDEF0_0FEDCBA9_87654321};
        tog_en = 1'b1;
        pulse_start();
        chk1("B_done_clr", done, 1'b0);
        chk1("B_busy", busy, 1'b1);
        chk("B_sig_clr", signature, 128'h0);
        chk("B_wc_clr", 128'(word_count), 128'd0);
        push_word(wa[0]);
        chk("B_sig_msb", signature, 128'h80000000_00000000_00000000_00000000);
        push_word(wa[1]);
        chk("B_sig_poly", signature, 128'h87);
        pulse_start();
        chk("B_start_ign_wc", 128'(word_count), 128'd2);
        chk("B_start_ign_sig", signature, 128'h87);
        chk1("B_start_ign_busy", busy, 1'b1);
        sig_m = 128'h87;
        for (int i = 2; i < 5; i++) begin
            push_word(wa[i]);
            sig_m = misr_m(sig_m, wa[i]);
        end
        wait_done(20);
        chk("B_sig_final", signature, sig_m);
        check_beats("B", wa);
        chk1("B_stalls_seen", stall_seen > 0, 1'b1);
        tog_en = 1'b0;

        // Run C: blocked sink fills the FIFO; no bypass on a same-cycle pop
        beats.delete();
        wa = '{128'h00000013_00000012_00000011_00000010,
               128'h00000023_00000022_00000021_00000020,
               128'h00000033_00000032_00000031_00000030,
               128'h00000043_00000042_00000041_00000040,
               128'h00000053_00000052_00000051_00000050};
        orq_man = 1'b0;
        pulse_start();
        sig_m = 128'h0;
        for (int i = 0; i < 4; i++) begin
            push_word(wa[i]);
            sig_m = misr_m(sig_m, wa[i]);
        end
        chk1("C_full_in_ready", in_ready, 1'b0);
        chk("C_wc4", 128'(word_count), 128'd4);
        chk1("C_held_valid", out_valid, 1'b1);
        chk("C_held_data", 128'(out_data), 128'h10);
        in_valid = 1'b1;
        in_data  = wa[4];
        tick();
        tick();
        chk("C_fifth_held_wc", 128'(word_count), 128'd4);
        chk("C_stall_data", 128'(out_data), 128'h10);
        chk1("C_stall_last", out_last, 1'b0);
        orq_man = 1'b1;
        tick();
        tick();
        tick();
        chk1("C_last_beat", out_last, 1'b1);
        chk("C_last_data", 128'(out_data), 128'h13);
        chk1("C_no_bypass", in_ready, 1'b0);
        tick();
        chk("C_pop_no_accept", 128'(word_count), 128'd4);
        chk1("C_ready_after_pop", in_ready, 1'b1);
        push_word(wa[4]);
        sig_m = misr_m(sig_m, wa[4]);
        chk("C_wc5", 128'(word_count), 128'd5);
        wait_done(20);
        chk("C_sig_final", signature, sig_m);
        check_beats("C", wa);

        // Run D: reset mid-word in DRAIN
        beats.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) push_word(wa[i]);
        tick();
        chk1("D_drain_busy", busy, 1'b1);
        chk1("D_drain_in_ready", in_ready, 1'b0);
        chk1("D_drain_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("D_rst_out_valid", out_valid, 1'b0);
        chk("D_rst_out_data", 128'(out_data), 128'h0);
        chk1("D_rst_out_last", out_last, 1'b0);
        chk("D_rst_sig", signature, 128'h0);
        chk("D_rst_wc", 128'(word_count), 128'd0);
        chk1("D_rst_busy", busy, 1'b0);
        chk1("D_rst_done", done, 1'b0);
        chk1("D_rst_in_ready", in_ready, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        beats.delete();

        // Run E: clean run after reset
        wa = '{128'hCAFEF00D_00000000_00000000_00000001, 128'h7,
               128'h80000000_00000000_00000000_00000001,
               128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF, 128'h1};
        pulse_start();
        push_word(wa[0]);
        chk("E_wc1", 128'(word_count), 128'd1);
        sig_m = wa[0];
        for (int i = 1; i < 5; i++) begin
            push_word(wa[i]);
            sig_m = misr_m(sig_m, wa[i]);
        end
        wait_done(20);
        chk("E_wc_final", 128'(word_count), 128'd5);
        chk("E_sig_final", signature, sig_m);
        check_beats("E", wa);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
